// File: rtl/cpu_ctl_pkg.sv
// Shared opcode and state encodings for the instruction-sequencing controller.
// Pure declarations; no logic or state.
package cpu_ctl_pkg;

  localparam int STATE_W = 4;

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_DEC = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SKZ = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    ST_PRE    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_OPER   = 4'd3,
    ST_EXEC   = 4'd4,
    ST_WB     = 4'd5,
    ST_DONE   = 4'd6,
    ST_HALTED = 4'd7
  } state_e;

  // Opcodes that read an operand from memory in OPER and EXEC.
  function automatic logic is_mem_rd(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/ctl_wait_timer.sv
// Purpose: counts stalled memory cycles in one phase and flags a bus error on overrun.
// Latency: timeout is combinational in the WAIT_MAX-th stalled cycle; bus_err registers on that edge.
// Backpressure: none; the counter clears as soon as a phase completes (stall low).
module ctl_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk1,
  input  logic rst,
  input  logic stall,
  output logic timeout,
  output logic bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] wait_cnt;

  // A ready in the last allowed cycle drops stall, so it completes without error.
  assign timeout = stall && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk1) begin
    if (rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (!stall || timeout) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_control_ext.sv
// Purpose: CPU instruction sequencer driving PC/ACC/IR/memory strobes, with halt and resume.
// Latency: PRE_IDLE+6 cycles per instruction without wait states; HLT parks after EXEC.
// Backpressure: with MEM_HS=1, memory phases hold on mem_ready=0 up to WAIT_MAX cycles.
module cpu_control_ext
  import cpu_ctl_pkg::*;
#(
  parameter int PRE_IDLE = 2,
  parameter int MEM_HS   = 0,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               inc_pc,
  output logic               load_acc,
  output logic               load_pc,
  output logic               rd,
  output logic               wr,
  output logic               load_ir,
  output logic               datactl_ena,
  output logic               halt,
  output logic               bus_err,
  output logic [STATE_W-1:0] state_dbg
);

  localparam state_e     START_ST  = (PRE_IDLE == 0) ? ST_FETCH : ST_PRE;
  localparam logic [2:0] IDLE_LAST = 3'((PRE_IDLE == 0) ? 0 : PRE_IDLE - 1);

  state_e     state;
  logic [2:0] idle_cnt;
  logic [2:0] op_q;
  logic       mem_ok;
  logic       rd_op;
  logic       stallable;
  logic       stall;
  logic       timeout;

  assign mem_ok    = (MEM_HS == 0) || mem_ready;
  assign rd_op     = is_mem_rd(op_q);
  assign stallable = (state == ST_FETCH)
                   || ((state == ST_OPER) && rd_op)
                   || ((state == ST_EXEC) && (rd_op || (op_q == OP_STO)));
  assign stall     = stallable && !mem_ok;

  ctl_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk1    (clk1),
    .rst     (rst),
    .stall   (stall),
    .timeout (timeout),
    .bus_err (bus_err)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state    <= START_ST;
      idle_cnt <= '0;
      op_q     <= OP_JMP;
    end else begin
      case (state)
        ST_PRE: begin
          if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
            state    <= ST_FETCH;
          end else begin
            idle_cnt <= idle_cnt + 3'd1;
          end
        end
        ST_FETCH: begin
          if (timeout)     state <= ST_HALTED;
          else if (!stall) state <= ST_DECODE;
        end
        ST_DECODE: begin
          // The instruction is fixed from here on, whatever the IR does later.
          op_q  <= opcode;
          state <= ST_OPER;
        end
        ST_OPER: begin
          if (timeout)     state <= ST_HALTED;
          else if (!stall) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (timeout || (op_q == OP_HLT)) state <= ST_HALTED;
          else if (!stall)                 state <= ST_WB;
        end
        ST_WB:     state <= ST_DONE;
        ST_DONE:   state <= START_ST;
        ST_HALTED: if (resume) state <= START_ST;
        default:   state <= ST_PRE;
      endcase
    end
  end

  always_comb begin
    inc_pc      = 1'b0;
    load_acc    = 1'b0;
    load_pc     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          rd      = 1'b1;
          load_ir = mem_ok;
        end
        ST_DECODE: inc_pc = 1'b1;
        ST_OPER: begin
          rd          = rd_op;
          load_pc     = (op_q == OP_JMP);
          datactl_ena = (op_q == OP_STO);
        end
        ST_EXEC: begin
          rd          = rd_op;
          load_acc    = (rd_op && mem_ok) || (op_q == OP_INC) || (op_q == OP_DEC);
          load_pc     = (op_q == OP_JMP);
          wr          = (op_q == OP_STO);
          datactl_ena = (op_q == OP_STO);
          inc_pc      = (op_q == OP_SKZ) && zero;
          halt        = (op_q == OP_HLT);
        end
        ST_WB: begin
          datactl_ena = rd_op || (op_q == OP_INC) || (op_q == OP_DEC) || (op_q == OP_STO);
        end
        ST_HALTED: halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_control_ext.sv
// Directed bench for three controller configurations: defaults, handshake with
// WAIT_MAX=4, and PRE_IDLE=0; expected strobe vectors are queued then checked per cycle.
module tb_cpu_control_ext;

  localparam logic [8:0] M_INC  = 9'h001;
  localparam logic [8:0] M_LACC = 9'h002;
  localparam logic [8:0] M_LPC  = 9'h004;
  localparam logic [8:0] M_RD   = 9'h008;
  localparam logic [8:0] M_WR   = 9'h010;
  localparam logic [8:0] M_LIR  = 9'h020;
  localparam logic [8:0] M_DEN  = 9'h040;
  localparam logic [8:0] M_HLT  = 9'h080;
  localparam logic [8:0] M_BERR = 9'h100;
  localparam logic [8:0] M_NONE = 9'h000;

  localparam logic [2:0] JMP = 3'b000, INC = 3'b001, DEC = 3'b010, ADD = 3'b011;
  localparam logic [2:0] SKZ = 3'b100, LDA = 3'b101, STO = 3'b110, HLT = 3'b111;

  logic       clk1;
  logic       rst         [3];
  logic [2:0] opcode      [3];
  logic       zero        [3];
  logic       mem_ready   [3];
  logic       resume      [3];
  logic       inc_pc      [3];
  logic       load_acc    [3];
  logic       load_pc     [3];
  logic       rd          [3];
  logic       wr          [3];
  logic       load_ir     [3];
  logic       datactl_ena [3];
  logic       halt        [3];
  logic       bus_err     [3];
  logic [3:0] state_dbg   [3];

  typedef struct {
    int          dut;
    string       tag;
    logic [12:0] exp;
  } sb_t;

  sb_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  cpu_control_ext u_def (
    .clk1(clk1), .rst(rst[0]), .opcode(opcode[0]), .zero(zero[0]),
    .mem_ready(mem_ready[0]), .resume(resume[0]), .inc_pc(inc_pc[0]),
    .load_acc(load_acc[0]), .load_pc(load_pc[0]), .rd(rd[0]), .wr(wr[0]),
    .load_ir(load_ir[0]), .datactl_ena(datactl_ena[0]), .halt(halt[0]),
    .bus_err(bus_err[0]), .state_dbg(state_dbg[0])
  );

  cpu_control_ext #(.PRE_IDLE(2), .MEM_HS(1), .WAIT_MAX(4)) u_hs (
    .clk1(clk1), .rst(rst[1]), .opcode(opcode[1]), .zero(zero[1]),
    .mem_ready(mem_ready[1]), .resume(resume[1]), .inc_pc(inc_pc[1]),
    .load_acc(load_acc[1]), .load_pc(load_pc[1]), .rd(rd[1]), .wr(wr[1]),
    .load_ir(load_ir[1]), .datactl_ena(datactl_ena[1]), .halt(halt[1]),
    .bus_err(bus_err[1]), .state_dbg(state_dbg[1])
  );

  cpu_control_ext #(.PRE_IDLE(0)) u_p0 (
    .clk1(clk1), .rst(rst[2]), .opcode(opcode[2]), .zero(zero[2]),
    .mem_ready(mem_ready[2]), .resume(resume[2]), .inc_pc(inc_pc[2]),
    .load_acc(load_acc[2]), .load_pc(load_pc[2]), .rd(rd[2]), .wr(wr[2]),
    .load_ir(load_ir[2]), .datactl_ena(datactl_ena[2]), .halt(halt[2]),
    .bus_err(bus_err[2]), .state_dbg(state_dbg[2])
  );

  function automatic logic [12:0] ev(input logic [3:0] st, input logic [8:0] m);
    return {st, m};
  endfunction

  function automatic logic [12:0] obs(input int d);
    return {state_dbg[d], bus_err[d], halt[d], datactl_ena[d], load_ir[d],
            wr[d], rd[d], load_pc[d], load_acc[d], inc_pc[d]};
  endfunction

  // Expected strobes for an unstalled instruction, by state number.
  function automatic logic [8:0] model(input int st, input logic [2:0] op, input logic z);
    logic [8:0] m;
    m = M_NONE;
    case (st)
      1: m = M_RD | M_LIR;
      2: m = M_INC;
      3: case (op)
           ADD, LDA: m = M_RD;
           JMP:      m = M_LPC;
           STO:      m = M_DEN;
           default:  m = M_NONE;
         endcase
      4: case (op)
           ADD, LDA: m = M_RD | M_LACC;
           INC, DEC: m = M_LACC;
           JMP:      m = M_LPC;
           STO:      m = M_WR | M_DEN;
           SKZ:      m = z ? M_INC : M_NONE;
           default:  m = M_HLT;
         endcase
      5: case (op)
           ADD, INC, DEC, LDA, STO: m = M_DEN;
           default:                 m = M_NONE;
         endcase
      default: m = M_NONE;
    endcase
    return m;
  endfunction

  task automatic push(input int d, input string tg, input logic [12:0] e);
    sb.push_back('{d, tg, e});
  endtask

  // Compare everything queued for this cycle, then step to just after the next edge.
  task automatic tick();
    sb_t         item;
    logic [12:0] o;
    @(negedge clk1);
    while (sb.size() > 0) begin
      item = sb.pop_front();
      o    = obs(item.dut);
      vectors++;
      assert (o === item.exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", item.tag, o, item.exp);
      end
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic reset_dut(input int d);
    rst[d] = 1'b1;
    @(posedge clk1);
    #1;
    rst[d] = 1'b0;
  endtask

  task automatic run_instr(input int d, input logic [2:0] op, input logic z,
                           input int npre, input bit scramble, input string tg);
    opcode[d] = op;
    zero[d]   = z;
    for (int i = 0; i < npre; i++) begin
      push(d, $sformatf("%s_pre%0d", tg, i), ev(4'd0, M_NONE));
      tick();
    end
    for (int s = 1; s <= 6; s++) begin
      push(d, $sformatf("%s_st%0d", tg, s), ev(4'(s), model(s, op, z)));
      tick();
      if (s == 2 && scramble) opcode[d] = ~op;
      if (s == 4 && op == HLT) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; opcode[i] = ADD; zero[i] = 1'b0;
      mem_ready[i] = 1'b1; resume[i] = 1'b0;
    end
    opcode[2] = JMP;
    @(posedge clk1);
    #1;

    // Reset state; u_p0 sits in FETCH but every strobe is masked by rst.
    push(0, "rst_def", ev(4'd0, M_NONE));
    push(1, "rst_hs",  ev(4'd0, M_NONE));
    push(2, "rst_p0",  ev(4'd1, M_NONE));
    tick();
    rst[0] = 1'b0;

    // Test 1: ADD back to back (next FETCH at cycle 10), then the other ALU/memory ops.
    run_instr(0, ADD, 1'b0, 2, 1'b0, "t1_add0");
    run_instr(0, ADD, 1'b0, 2, 1'b0, "t1_add1");
    mem_ready[0] = 1'b0;
    run_instr(0, LDA, 1'b0, 2, 1'b0, "t1_lda_nohs");
    mem_ready[0] = 1'b1;
    run_instr(0, INC, 1'b0, 2, 1'b1, "t1_inc_latch");
    run_instr(0, DEC, 1'b0, 2, 1'b0, "t1_dec");
    run_instr(0, STO, 1'b0, 2, 1'b0, "t1_sto");
    run_instr(0, JMP, 1'b0, 2, 1'b0, "t1_jmp");

    // Test 2: SKZ with zero set then clear.
    reset_dut(0);
    run_instr(0, SKZ, 1'b1, 2, 1'b0, "t2_skz_z1");
    run_instr(0, SKZ, 1'b0, 2, 1'b0, "t2_skz_z0");

    // Test 3: HLT parks from cycle 5; resume at cycle 20.
    reset_dut(0);
    run_instr(0, HLT, 1'b0, 2, 1'b0, "t3_hlt");
    for (int c = 6; c < 20; c++) begin
      push(0, $sformatf("t3_halted_c%0d", c), ev(4'd7, M_HLT));
      tick();
    end
    resume[0] = 1'b1;
    push(0, "t3_resume_c20", ev(4'd7, M_HLT));
    tick();
    resume[0] = 1'b0;
    push(0, "t3_pre_c21", ev(4'd0, M_NONE));
    tick();
    push(0, "t3_pre_c22", ev(4'd0, M_NONE));
    tick();
    push(0, "t3_fetch_c23", ev(4'd1, M_RD | M_LIR));
    tick();

    // Test 4: FETCH stalls 3 cycles, ready on the WAIT_MAX-th; one EXEC stall on ADD.
    rst[1] = 1'b0;
    opcode[1] = ADD;
    push(1, "t4_pre0", ev(4'd0, M_NONE)); tick();
    push(1, "t4_pre1", ev(4'd0, M_NONE)); tick();
    mem_ready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      push(1, $sformatf("t4_fetch_stall%0d", c), ev(4'd1, M_RD));
      tick();
    end
    mem_ready[1] = 1'b1;
    push(1, "t4_fetch_done", ev(4'd1, M_RD | M_LIR)); tick();
    push(1, "t4_decode",     ev(4'd2, M_INC));        tick();
    push(1, "t4_oper",       ev(4'd3, M_RD));         tick();
    mem_ready[1] = 1'b0;
    push(1, "t4_exec_stall", ev(4'd4, M_RD));         tick();
    mem_ready[1] = 1'b1;
    push(1, "t4_exec_done",  ev(4'd4, M_RD | M_LACC)); tick();
    push(1, "t4_wb",         ev(4'd5, M_DEN));        tick();
    push(1, "t4_done",       ev(4'd6, M_NONE));       tick();

    // Test 5: STO write never acknowledged -> bus error, sticky across resume.
    opcode[1] = STO;
    push(1, "t5_pre0",   ev(4'd0, M_NONE));      tick();
    push(1, "t5_pre1",   ev(4'd0, M_NONE));      tick();
    push(1, "t5_fetch",  ev(4'd1, M_RD | M_LIR)); tick();
    push(1, "t5_decode", ev(4'd2, M_INC));       tick();
    push(1, "t5_oper",   ev(4'd3, M_DEN));       tick();
    mem_ready[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      push(1, $sformatf("t5_wr_stall%0d", c), ev(4'd4, M_WR | M_DEN));
      tick();
    end
    push(1, "t5_halted0", ev(4'd7, M_HLT | M_BERR)); tick();
    resume[1] = 1'b1;
    push(1, "t5_halted1", ev(4'd7, M_HLT | M_BERR)); tick();
    resume[1] = 1'b0;
    mem_ready[1] = 1'b1;
    push(1, "t5_berr_pre0",  ev(4'd0, M_BERR));                tick();
    push(1, "t5_berr_pre1",  ev(4'd0, M_BERR));                tick();
    push(1, "t5_berr_fetch", ev(4'd1, M_RD | M_LIR | M_BERR)); tick();
    reset_dut(1);
    push(1, "t5_berr_clr",   ev(4'd0, M_NONE));                tick();

    // Test 6: PRE_IDLE=0 JMP stream, then reset mid-EXEC.
    rst[2] = 1'b0;
    run_instr(2, JMP, 1'b0, 0, 1'b0, "t6_jmp0");
    run_instr(2, JMP, 1'b0, 0, 1'b0, "t6_jmp1");
    push(2, "t6_fetch",  ev(4'd1, M_RD | M_LIR)); tick();
    push(2, "t6_decode", ev(4'd2, M_INC));        tick();
    push(2, "t6_oper",   ev(4'd3, M_LPC));        tick();
    rst[2] = 1'b1;
    push(2, "t6_rst_exec",  ev(4'd4, M_NONE));    tick();
    push(2, "t6_rst_fetch", ev(4'd1, M_NONE));    tick();
    rst[2] = 1'b0;
    push(2, "t6_fetch_after", ev(4'd1, M_RD | M_LIR)); tick();
    push(2, "t6_decode_after", ev(4'd2, M_INC));       tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_control_ext.md
Name: cpu_control_ext

Overview:
Parametrised next-generation instruction-sequencing controller for the simple CPU. Replaces the fixed 8-phase, 2-bit-opcode controller.
- Keeps the JMP/INC/DEC/ADD encodings unchanged.
- Adds SKZ, LDA, STO and HLT.
- Adds a configurable pre-fetch idle length, a memory ready handshake with wait-state timeout, and a resumable halt.
Drives the PC, accumulator, IR, memory read/write and data-bus enable strobes.

Parameters:
PRE_IDLE, 2, idle cycles before each fetch; legal range 0..7.
MEM_HS, 0, 1 = rd/wr phases stall on mem_ready; 0 = mem_ready ignored, treated as 1.
WAIT_MAX, 15, maximum stall cycles in one phase before bus error; legal range 1..255.

Ports:
clk1  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
opcode  in  3  IR opcode field; valid from the cycle after load_ir.
zero  in  1  accumulator-zero flag; sampled in EXEC.
mem_ready  in  1  memory handshake; the access completes in a cycle with mem_ready=1.
resume  in  1  leave HALTED.
inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt  out  1 each  datapath strobes.
bus_err  out  1  sticky wait-state timeout flag.
state_dbg  out  4  current state encoding.

Behaviour:
- Reset (rst=1 at an edge):
  - State becomes PRE, idle counter 0, wait counter 0, bus_err 0.
  - With PRE_IDLE=0, reset goes to FETCH instead.
  - All strobes are 0 while in reset. rst overrides every other input, including mid-stall and in HALTED.
- Opcodes:
  - 000 JMP, 001 INC, 010 DEC, 011 ADD (legacy encodings).
  - 100 SKZ, 101 LDA, 110 STO, 111 HLT.
- States:
  - PRE → FETCH → DECODE → OPER → EXEC → WB → DONE → PRE.
  - Plus HALTED. Unused encodings go to PRE with all strobes 0.
- PRE: held for PRE_IDLE cycles; all strobes 0.
- FETCH: rd=1. load_ir=1 only in the completing cycle (mem_ready=1).
- DECODE: inc_pc=1 for exactly one cycle.
- OPER:
  - ADD/LDA: rd=1 (stallable).
  - JMP: load_pc=1.
  - STO: datactl_ena=1.
  - Others: all strobes 0.
- EXEC:
  - ADD/LDA: rd=1; load_acc=1 only in the completing cycle.
  - INC/DEC: load_acc=1.
  - JMP: load_pc=1.
  - STO: wr=1 and datactl_ena=1 (stallable).
  - SKZ: inc_pc=1 iff zero=1.
  - HLT: halt=1, next state HALTED.
- WB:
  - ADD/INC/DEC/LDA/STO: datactl_ena=1.
  - Others: all strobes 0.
- DONE: all strobes 0. Next state is PRE, or FETCH when PRE_IDLE=0.
- HALTED:
  - halt=1 held, all other strobes 0.
  - resume=1 moves to PRE (or FETCH) on the next edge.
  - resume is ignored in every other state.
- Latency:
  - Without stalls every instruction takes PRE_IDLE+6 cycles (8 with defaults).
  - HLT stops after EXEC.
- Stall (MEM_HS=1 only):
  - In a stallable phase with mem_ready=0, state holds and rd/wr stay asserted.
  - load_ir/load_acc stay 0; other strobes are not repeated.
  - The wait counter increments per stalled cycle and clears on phase completion.
  - When the counter reaches WAIT_MAX with mem_ready still 0: next state HALTED, bus_err set to 1.
  - bus_err stays 1 until rst; resume does not clear it.
  - mem_ready=1 on the WAIT_MAX-th cycle completes normally, with no error.
- load_ir and load_acc are the only Mealy strobes (gated by mem_ready). All others are a function of state, the opcode registered at DECODE, and zero.
- Opcode is latched at the DECODE edge; later changes on the opcode input do not affect the current instruction.
- state_dbg encoding: PRE=0, FETCH=1, DECODE=2, OPER=3, EXEC=4, WB=5, DONE=6, HALTED=7.

Decomposition:
- Package cpu_ctl_pkg holds:
  - opcode localparams (OP_JMP..OP_HLT);
  - state encodings (ST_PRE..ST_HALTED);
  - the state width (4).
- One natural sub-module, ctl_wait_timer:
  - wait counter with clear/increment;
  - timeout compare against WAIT_MAX;
  - sticky bus_err register.

Test Plan:
1. Defaults, rst released, opcode=011 (ADD), mem_ready=1 → FETCH at cycle 2. inc_pc at cycle 3. rd at 4. rd+load_acc at 5. datactl_ena at 6. Next FETCH at cycle 10.
2. opcode=100 (SKZ): with zero=1 → inc_pc=1 in EXEC (cycle 5) in addition to DECODE. With zero=0 → a single inc_pc per instruction.
3. opcode=111 (HLT) → halt=1 from cycle 5 onward, state_dbg=7. resume pulse at cycle 20 → PRE at 21, FETCH at 23.
4. MEM_HS=1, mem_ready=0 for 3 cycles in FETCH → rd held 4 cycles. load_ir=1 only in the 4th. DECODE follows and the instruction otherwise completes normally.
5. MEM_HS=1, WAIT_MAX=4, mem_ready stuck 0 during STO EXEC → wr held 4 cycles, then HALTED with bus_err=1. resume → bus_err stays 1. rst → bus_err=0.
6. PRE_IDLE=0, JMP stream → FETCH immediately after reset and directly after each DONE (6-cycle instructions), load_pc=1 in OPER and EXEC. rst asserted mid-EXEC → all strobes 0 the next cycle, then FETCH.
